rect_plot_ctrl: RTL and testbench
=================================

// Module: rect_plot_ctrl
// PURPOSE
// - Button-driven pixel/rectangle plotter. Replaces single-pixel load-X / load-Y / plot
//   control with a parametrised rectangle fill and a full-screen clear.
// - Sits between board KEY/SW inputs and the vga_adapter write port, driving x, y, colour and plot.
// - Also serves as the draw engine for bricks and paddle, through the same strobes.
// PARAMETERS
// - X_W       8    x coordinate width
// - Y_W       7    y coordinate width
// - COL_W     3    colour width
// - SZ_W      4    rectangle size field width (max 2^SZ_W pixels per side)
// - SCREEN_W  160  visible columns; x >= SCREEN_W is off-screen
// - SCREEN_H  120  visible rows; y >= SCREEN_H is off-screen
// PORTS
// - CLOCK_50    in   1      system clock; all state on the rising edge
// - resetn      in   1      asynchronous, active-low reset
// - ld_x_n      in   1      active-low button; press loads x0 <= data_in
// - ld_y_n      in   1      active-low button; press loads y0 <= data_in[Y_W-1:0]
// - plot_n      in   1      active-low button; press starts rectangle fill
// - clear_n     in   1      active-low button; press starts full-screen clear
// - data_in     in   X_W    coordinate data (switches)
// - colour_in   in   COL_W  fill colour, latched at fill start
// - size_w      in   SZ_W   rectangle width minus 1, latched at fill start
// - size_h      in   SZ_W   rectangle height minus 1, latched at fill start
// - x_out       out  X_W    registered pixel x
// - y_out       out  Y_W    registered pixel y
// - colour_out  out  COL_W  registered pixel colour
// - plot        out  1      registered write enable to vga_adapter
// - busy        out  1      high while in FILL or CLEAR
// - done        out  1      one-cycle pulse after the last pixel of a command
// BEHAVIOUR
// - Reset
//   - All outputs, x0, y0 and counters go to 0 immediately; state = IDLE.
//   - Button sync flops reset to 1 (released), so reset never produces a spurious press.
// - Button input
//   - Each button passes through a 2-flop synchroniser plus a history flop.
//   - press = history & ~sync2 (falling edge): exactly one pulse per press, however long held.
// - Latency: for the edge that first samples plot_n/clear_n low as edge 1, the FSM leaves IDLE
//   on edge 3 and plot (if on-screen) is high for the cycle after edge 3.
// - Loads
//   - ld_x/ld_y presses are accepted in any state.
//   - They change x0/y0 only; an active command uses its own copies latched at start.
//   - Simultaneous ld_x and ld_y presses load both registers from the same data_in.
// - FSM states: IDLE, FILL, CLEAR, DONE
//   - IDLE -> CLEAR on clear press. CLEAR has priority if both presses land in the same cycle.
//   - IDLE -> FILL on plot press. Latches x0, y0, colour_in, size_w, size_h; cx = cy = 0.
//   - FILL emits one pixel per cycle, row-major: cx is the inner loop, 0..size_w;
//     cy is the outer loop, 0..size_h.
//   - x = x0 + cx at X_W+1 bits and y = y0 + cy at Y_W+1 bits: no wrap-around.
//   - Off-screen pixels hold plot = 0 for their cycle. The counters still advance, so FILL
//     always lasts (size_w+1)*(size_h+1) cycles.
//   - CLEAR scans x 0..SCREEN_W-1 (inner) and y 0..SCREEN_H-1 with colour 0 and plot = 1:
//     SCREEN_W*SCREEN_H cycles.
//   - After the last pixel cycle: DONE for 1 cycle (done = 1, plot = 0, busy = 0), then IDLE.
//   - plot/clear presses while busy or in DONE are dropped, not queued.
// - Outputs
//   - x_out, y_out and colour_out hold their last values when plot = 0.
//   - busy = 1 exactly in the cycles where FILL/CLEAR pixels are presented.
// - Reset mid-command aborts it: no done pulse, outputs 0, and no plot until a new press.
// TESTING
// - Single pixel.
//   - Stimulus: reset; ld_x with data_in = 4; ld_y with data_in = 4; colour_in = 3'b100;
//     size_w = size_h = 0; press plot.
//   - Response: exactly 1 plot cycle at (4,4) colour 4; done on the next cycle.
// - Small rectangle.
//   - Stimulus: x0 = 10, y0 = 20, size_w = 2, size_h = 1.
//   - Response: 6 consecutive plot cycles at (10,20) (11,20) (12,20) (10,21) (11,21) (12,21);
//     busy high for exactly 6 cycles.
// - Edge clipping.
//   - Stimulus: x0 = 158, y0 = 0, size_w = 3, size_h = 0.
//   - Response: plot high at x = 158 and 159 only; busy 4 cycles; x never wraps to 0/1.
// - Clear.
//   - Stimulus: press clear, and press plot midway through.
//   - Response: 19200 plot cycles with colour 0; last pixel (159,119); one done pulse;
//     the mid-way plot press is ignored.
// - Simultaneous commands and long hold.
//   - Stimulus: clear and plot pressed in the same cycle; separately, plot_n held low 100 cycles.
//   - Response: clear runs first; the long hold starts exactly one fill.
// - Reset mid-fill.
//   - Stimulus: assert resetn low during a 16x16 fill.
//   - Response: plot, busy, x_out and y_out drop to 0 without waiting for a clock edge;
//     after release, no plot until a new press.

Source files
------------

// File: rtl/rect_plot_ctrl_if.sv
// Board-side bundle for rect_plot_ctrl: button strobes, switch/colour/size inputs
// and the registered pixel write port toward the vga_adapter.
interface rect_plot_ctrl_if #(
    parameter int X_W   = 8,
    parameter int Y_W   = 7,
    parameter int COL_W = 3,
    parameter int SZ_W  = 4
);
    logic             ld_x_n;
    logic             ld_y_n;
    logic             plot_n;
    logic             clear_n;
    logic [X_W-1:0]   data_in;
    logic [COL_W-1:0] colour_in;
    logic [SZ_W-1:0]  size_w;
    logic [SZ_W-1:0]  size_h;
    logic [X_W-1:0]   x_out;
    logic [Y_W-1:0]   y_out;
    logic [COL_W-1:0] colour_out;
    logic             plot;
    logic             busy;
    logic             done;

    modport master (
        output ld_x_n, ld_y_n, plot_n, clear_n, data_in, colour_in, size_w, size_h,
        input  x_out, y_out, colour_out, plot, busy, done
    );

    modport slave (
        input  ld_x_n, ld_y_n, plot_n, clear_n, data_in, colour_in, size_w, size_h,
        output x_out, y_out, colour_out, plot, busy, done
    );
endinterface

// File: rtl/rect_plot_ctrl.sv
// Button-driven rectangle plotter / screen clearer feeding the vga_adapter write port,
// one pixel per clock with off-screen pixels suppressed.
module rect_plot_ctrl #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COL_W    = 3,
    parameter int SZ_W     = 4,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input logic             CLOCK_50,
    input logic             resetn,
    rect_plot_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FILL, CLEAR, DONE} state_t;

    logic [3:0]       r_sync1;
    logic [3:0]       r_sync2;
    logic [3:0]       r_hist;
    logic [3:0]       w_btn;
    logic [3:0]       w_press;
    logic             w_ldXPress;
    logic             w_ldYPress;
    logic             w_plotPress;
    logic             w_clrPress;

    logic [X_W-1:0]   r_x0;
    logic [Y_W-1:0]   r_y0;

    state_t           r_state;
    state_t           w_nState;
    logic [X_W-1:0]   r_cx;
    logic [X_W-1:0]   w_nCx;
    logic [Y_W-1:0]   r_cy;
    logic [Y_W-1:0]   w_nCy;
    logic [X_W-1:0]   r_bx;
    logic [X_W-1:0]   w_nBx;
    logic [Y_W-1:0]   r_by;
    logic [Y_W-1:0]   w_nBy;
    logic [COL_W-1:0] r_col;
    logic [COL_W-1:0] w_nCol;
    logic [X_W-1:0]   r_lastX;
    logic [X_W-1:0]   w_nLastX;
    logic [Y_W-1:0]   r_lastY;
    logic [Y_W-1:0]   w_nLastY;

    logic             w_emit;
    logic [X_W:0]     w_pixX;
    logic [Y_W:0]     w_pixY;
    logic             w_onScreen;

    logic [X_W-1:0]   r_xOut;
    logic [Y_W-1:0]   r_yOut;
    logic [COL_W-1:0] r_colOut;
    logic             r_plot;

    assign w_btn = {bus.clear_n, bus.plot_n, bus.ld_y_n, bus.ld_x_n};

    // Flops reset to "released" so leaving reset can never look like a press.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
            r_hist  <= '1;
        end else begin
            r_sync1 <= w_btn;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
        end
    end

    assign w_press     = r_hist & ~r_sync2;
    assign w_ldXPress  = w_press[0];
    assign w_ldYPress  = w_press[1];
    assign w_plotPress = w_press[2];
    assign w_clrPress  = w_press[3];

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_x0 <= '0;
            r_y0 <= '0;
        end else begin
            if (w_ldXPress) r_x0 <= bus.data_in;
            if (w_ldYPress) r_y0 <= bus.data_in[Y_W-1:0];
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_cx    <= '0;
            r_cy    <= '0;
            r_bx    <= '0;
            r_by    <= '0;
            r_col   <= '0;
            r_lastX <= '0;
            r_lastY <= '0;
        end else begin
            r_state <= w_nState;
            r_cx    <= w_nCx;
            r_cy    <= w_nCy;
            r_bx    <= w_nBx;
            r_by    <= w_nBy;
            r_col   <= w_nCol;
            r_lastX <= w_nLastX;
            r_lastY <= w_nLastY;
        end
    end

    // Counters always name the pixel currently on the outputs; a clear is a fill
    // anchored at the origin with the screen as its extent.
    always_comb begin
        w_nState = r_state;
        w_nCx    = r_cx;
        w_nCy    = r_cy;
        w_nBx    = r_bx;
        w_nBy    = r_by;
        w_nCol   = r_col;
        w_nLastX = r_lastX;
        w_nLastY = r_lastY;
        case (r_state)
            IDLE: begin
                if (w_clrPress) begin
                    w_nState = CLEAR;
                    w_nCx    = '0;
                    w_nCy    = '0;
                    w_nBx    = '0;
                    w_nBy    = '0;
                    w_nCol   = '0;
                    w_nLastX = X_W'(SCREEN_W - 1);
                    w_nLastY = Y_W'(SCREEN_H - 1);
                end else if (w_plotPress) begin
                    w_nState = FILL;
                    w_nCx    = '0;
                    w_nCy    = '0;
                    w_nBx    = r_x0;
                    w_nBy    = r_y0;
                    w_nCol   = bus.colour_in;
                    w_nLastX = X_W'(bus.size_w);
                    w_nLastY = Y_W'(bus.size_h);
                end
            end
            FILL, CLEAR: begin
                if (r_cx == r_lastX) begin
                    if (r_cy == r_lastY) begin
                        w_nState = DONE;
                    end else begin
                        w_nCx = '0;
                        w_nCy = r_cy + Y_W'(1);
                    end
                end else begin
                    w_nCx = r_cx + X_W'(1);
                end
            end
            DONE: begin
                w_nState = IDLE;
            end
            default: begin
                w_nState = IDLE;
            end
        endcase
    end

    assign w_emit     = (w_nState == FILL) || (w_nState == CLEAR);
    assign w_pixX     = (X_W+1)'(w_nBx) + (X_W+1)'(w_nCx);
    assign w_pixY     = (Y_W+1)'(w_nBy) + (Y_W+1)'(w_nCy);
    assign w_onScreen = (w_pixX < (X_W+1)'(SCREEN_W)) && (w_pixY < (Y_W+1)'(SCREEN_H));

    // Pixel outputs only move on a real write so the adapter sees stable values otherwise.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_plot   <= 1'b0;
            r_xOut   <= '0;
            r_yOut   <= '0;
            r_colOut <= '0;
        end else begin
            r_plot <= w_emit && w_onScreen;
            if (w_emit && w_onScreen) begin
                r_xOut   <= w_pixX[X_W-1:0];
                r_yOut   <= w_pixY[Y_W-1:0];
                r_colOut <= w_nCol;
            end
        end
    end

    assign bus.x_out      = r_xOut;
    assign bus.y_out      = r_yOut;
    assign bus.colour_out = r_colOut;
    assign bus.plot       = r_plot;
    assign bus.busy       = (r_state == FILL) || (r_state == CLEAR);
    assign bus.done       = (r_state == DONE);
endmodule

// File: tb/tb_rect_plot_ctrl.sv
// Self-checking bench for rect_plot_ctrl: directed and random rectangles, clears,
// button edge cases and asynchronous reset, checked against a loop-based pixel model.
module tb_rect_plot_ctrl;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COL_W    = 3;
    localparam int SZ_W     = 4;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    logic clock = 1'b0;
    logic resetn = 1'b0;

    int checkCount = 0;
    int passCount = 0;

    int modelX0 = 0;
    int modelY0 = 0;
    int expX = 0;
    int expY = 0;
    int expCol = 0;

    int holdLdX = 0;
    int holdLdY = 0;
    int holdPlot = 0;
    int holdClr = 0;

    always #5 clock = ~clock;

    rect_plot_ctrl_if #(.X_W(X_W), .Y_W(Y_W), .COL_W(COL_W), .SZ_W(SZ_W)) bus();

    rect_plot_ctrl #(
        .X_W(X_W), .Y_W(Y_W), .COL_W(COL_W), .SZ_W(SZ_W),
        .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)
    ) dut (
        .CLOCK_50(clock),
        .resetn  (resetn),
        .bus     (bus)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) begin
            passCount++;
        end else begin
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Advance to the next falling edge, then release any button whose hold has elapsed.
    task automatic tick();
        @(negedge clock);
        if (holdLdX > 0) begin holdLdX--; if (holdLdX == 0) bus.ld_x_n = 1'b1; end
        if (holdLdY > 0) begin holdLdY--; if (holdLdY == 0) bus.ld_y_n = 1'b1; end
        if (holdPlot > 0) begin holdPlot--; if (holdPlot == 0) bus.plot_n = 1'b1; end
        if (holdClr > 0) begin holdClr--; if (holdClr == 0) bus.clear_n = 1'b1; end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, ".plot"}, 32'(bus.plot), 0);
        checkOutput({tag, ".busy"}, 32'(bus.busy), 0);
        checkOutput({tag, ".done"}, 32'(bus.done), 0);
        checkOutput({tag, ".x"}, 32'(bus.x_out), expX);
        checkOutput({tag, ".y"}, 32'(bus.y_out), expY);
        checkOutput({tag, ".col"}, 32'(bus.colour_out), expCol);
    endtask

    task automatic applyStimulus(input bit doClear, input bit doPlot, input int hold);
        if (doClear) begin bus.clear_n = 1'b0; holdClr = hold; end
        if (doPlot) begin bus.plot_n = 1'b0; holdPlot = hold; end
    endtask

    task automatic loadCoords(input bit doX, input bit doY, input logic [7:0] data);
        bus.data_in = data;
        if (doX) begin bus.ld_x_n = 1'b0; holdLdX = 1; end
        if (doY) begin bus.ld_y_n = 1'b0; holdLdY = 1; end
        for (int i = 0; i < 4; i++) begin
            tick();
            checkIdle("load");
        end
        if (doX) modelX0 = data;
        if (doY) modelY0 = data % 128;
    endtask

    // Expected pixel stream: row-major over the rectangle, no wrap, off-screen suppressed.
    task automatic issueCommand(input bit doClear, input bit doPlot, input int hold,
                                input int w, input int h, input int col,
                                input int midPlotAt, input int ldAt, input logic [7:0] ldData);
        int bx, by, lastC, lastR, fillCol, idx, px, py;
        bit on;
        if (!doClear) begin
            bus.colour_in = col[2:0];
            bus.size_w    = w[3:0];
            bus.size_h    = h[3:0];
        end
        bx      = doClear ? 0 : modelX0;
        by      = doClear ? 0 : modelY0;
        lastC   = doClear ? SCREEN_W - 1 : w;
        lastR   = doClear ? SCREEN_H - 1 : h;
        fillCol = doClear ? 0 : col;
        applyStimulus(doClear, doPlot, hold);
        tick();
        checkIdle("lat1");
        tick();
        checkIdle("lat2");
        idx = 0;
        for (int r = 0; r <= lastR; r++) begin
            for (int c = 0; c <= lastC; c++) begin
                tick();
                px = bx + c;
                py = by + r;
                on = (px < SCREEN_W) && (py < SCREEN_H);
                if (on) begin
                    expX = px;
                    expY = py;
                    expCol = fillCol;
                end
                checkOutput("pix.plot", 32'(bus.plot), 32'(on));
                checkOutput("pix.busy", 32'(bus.busy), 1);
                checkOutput("pix.done", 32'(bus.done), 0);
                checkOutput("pix.x", 32'(bus.x_out), expX);
                checkOutput("pix.y", 32'(bus.y_out), expY);
                checkOutput("pix.col", 32'(bus.colour_out), expCol);
                if (idx == midPlotAt) applyStimulus(1'b0, 1'b1, 2);
                if (idx == ldAt) begin
                    bus.data_in = ldData;
                    bus.ld_x_n = 1'b0;
                    holdLdX = 1;
                end
                idx++;
            end
        end
        tick();
        checkOutput("end.done", 32'(bus.done), 1);
        checkOutput("end.busy", 32'(bus.busy), 0);
        checkOutput("end.plot", 32'(bus.plot), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkIdle("after");
        end
        if (ldAt >= 0) modelX0 = ldData;
    endtask

    initial begin
        int w, h, col, ldAt;
        logic [7:0] d;
        bus.ld_x_n = 1'b1;
        bus.ld_y_n = 1'b1;
        bus.plot_n = 1'b1;
        bus.clear_n = 1'b1;
        bus.data_in = '0;
        bus.colour_in = '0;
        bus.size_w = '0;
        bus.size_h = '0;
        resetn = 1'b0;
        repeat (3) @(negedge clock);
        checkIdle("reset");
        resetn = 1'b1;
        tick();
        checkIdle("postreset");

        $display("[TB] single pixel");
        loadCoords(1, 0, 8'd4);
        loadCoords(0, 1, 8'd4);
        issueCommand(0, 1, 1, 0, 0, 4, -1, -1, 8'd0);

        $display("[TB] small rectangle");
        loadCoords(1, 1, 8'd20);
        loadCoords(1, 0, 8'd10);
        issueCommand(0, 1, 1, 2, 1, 5, -1, -1, 8'd0);

        $display("[TB] edge clipping");
        loadCoords(1, 0, 8'd158);
        loadCoords(0, 1, 8'd0);
        issueCommand(0, 1, 1, 3, 0, 6, -1, -1, 8'd0);
        loadCoords(1, 1, 8'd118);
        issueCommand(0, 1, 3, 2, 3, 2, -1, 1, 8'd157);
        issueCommand(0, 1, 1, 3, 1, 7, -1, -1, 8'd0);

        $display("[TB] random rectangles");
        for (int k = 0; k < 10; k++) begin
            if ($urandom_range(0, 1) == 1) begin
                d = 8'($urandom_range(0, 255));
                loadCoords(1, 0, d);
                d = 8'($urandom_range(0, 255));
                loadCoords(0, 1, d);
            end
            w = $urandom_range(0, 15);
            h = $urandom_range(0, 15);
            col = $urandom_range(0, 7);
            ldAt = ($urandom_range(0, 1) == 1) ? $urandom_range(0, (w + 1) * (h + 1) - 1) : -1;
            issueCommand(0, 1, $urandom_range(1, 6), w, h, col, -1, ldAt, 8'($urandom_range(0, 255)));
        end

        $display("[TB] clear with plot press midway");
        issueCommand(1, 0, 2, 0, 0, 0, 9600, -1, 8'd0);

        $display("[TB] clear and plot together");
        issueCommand(1, 1, 2, 0, 0, 0, -1, -1, 8'd0);

        $display("[TB] long plot hold");
        loadCoords(1, 1, 8'd30);
        issueCommand(0, 1, 100, 1, 1, 3, -1, -1, 8'd0);
        for (int i = 0; i < 100; i++) begin
            tick();
            checkIdle("hold");
        end

        $display("[TB] reset mid-fill");
        loadCoords(1, 1, 8'd50);
        bus.size_w = 4'd15;
        bus.size_h = 4'd15;
        bus.colour_in = 3'd5;
        applyStimulus(0, 1, 1);
        repeat (2) tick();
        repeat (20) tick();
        checkOutput("midfill.busy", 32'(bus.busy), 1);
        checkOutput("midfill.plot", 32'(bus.plot), 1);
        #2;
        resetn = 1'b0;
        #1;
        expX = 0;
        expY = 0;
        expCol = 0;
        modelX0 = 0;
        modelY0 = 0;
        checkIdle("asyncreset");
        @(negedge clock);
        resetn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checkIdle("afterreset");
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
